// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus lengths, payload layouts,
// load-op bit indices and FSM state encoding.
`ifndef MEM_STAGE_DEFS_SVH
`define MEM_STAGE_DEFS_SVH
`define DEST_LEN       5
`define EXE_to_MEM_LEN 205
`define MEM_to_WB_LEN  166
`define MEM_RF_LEN     54
`endif

package mem_stage_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned EXC_W     = 15;
  localparam int unsigned DEST_W    = `DEST_LEN;
  localparam int unsigned CSR_NUM_W = 14;
  localparam int unsigned LOAD_OP_W = 5;

  // one-hot load_op bit positions
  localparam int unsigned LD_B  = 0;
  localparam int unsigned LD_BU = 1;
  localparam int unsigned LD_H  = 2;
  localparam int unsigned LD_HU = 3;
  localparam int unsigned LD_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic                 gr_we;
    logic [DEST_W-1:0]    dest;
    logic [XLEN-1:0]      exe_result;
    logic [XLEN-1:0]      st_data;
    logic                 mem_en;
    logic [LOAD_OP_W-1:0] load_op;
    logic                 rfrom_mem;
    logic [CSR_NUM_W-1:0] csr_num;
    logic                 csr_we;
    logic [XLEN-1:0]      csr_wvalue;
    logic [XLEN-1:0]      csr_wmask;
    logic                 ex;
    logic [EXC_W-1:0]     ex_code;
    logic                 ertn;
  } exe_to_mem_t;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic                 gr_we;
    logic [DEST_W-1:0]    dest;
    logic [XLEN-1:0]      final_result;
    logic [CSR_NUM_W-1:0] csr_num;
    logic                 csr_we;
    logic [XLEN-1:0]      csr_wvalue;
    logic [XLEN-1:0]      csr_wmask;
    logic                 ex;
    logic [EXC_W-1:0]     ex_code;
    logic                 ertn;
  } mem_to_wb_t;

  typedef struct packed {
    logic [DEST_W-1:0]    dest;
    logic                 waiting_load;
    logic [XLEN-1:0]      final_result;
    logic                 valid;
    logic                 csr_we;
    logic [CSR_NUM_W-1:0] csr_num;
  } mem_rf_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load data aligner: selects byte/half/word from a word-aligned
// SRAM read and sign- or zero-extends it according to the one-hot load_op.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [XLEN-1:0]      rdata_i,
  input  logic [1:0]           off_i,
  input  logic [LOAD_OP_W-1:0] load_op_i,
  output logic [XLEN-1:0]      value_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = 8'(rdata_i >> {off_i, 3'b000});
  assign half_v = 16'(rdata_i >> {off_i[1], 4'b0000});

  always_comb begin
    value_o = rdata_i;
    if (load_op_i[LD_B]) begin
      value_o = {{(XLEN-8){byte_v[7]}}, byte_v};
    end else if (load_op_i[LD_BU]) begin
      value_o = {{(XLEN-8){1'b0}}, byte_v};
    end else if (load_op_i[LD_H]) begin
      value_o = {{(XLEN-16){half_v[15]}}, half_v};
    end else if (load_op_i[LD_HU]) begin
      value_o = {{(XLEN-16){1'b0}}, half_v};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for data-SRAM responses, aligns loads and
// drops responses of flushed requests. Optional MEM_PERF_CNT_EN adds a load-stall counter.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       exe_to_mem_valid_i,
  output logic                       mem_allowin_o,
  input  logic [`EXE_to_MEM_LEN-1:0] exe_to_mem_bus_i,
  input  logic                       data_req_fire_i,
  input  logic                       data_sram_data_ok_i,
  input  logic [XLEN-1:0]            data_sram_rdata_i,
  input  logic                       wb_allowin_i,
  output logic                       mem_to_wb_valid_o,
  output logic [`MEM_to_WB_LEN-1:0]  mem_to_wb_bus_o,
  output logic [`MEM_RF_LEN-1:0]     mem_rf_bus_o,
  output logic                       mem_ex_o,
  output logic                       mem_ertn_o,
  input  logic                       ertn_flush_i,
  input  logic                       wb_ex_i
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [31:0]                perf_load_stall_o
`endif
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
  localparam int unsigned SUM_W = CNT_W + 2;

  exe_to_mem_t      bus_in, bus_q, bus_d;
  mem_state_e       state_q, state_d;
  logic             mem_valid_q, mem_valid_d;
  logic [XLEN-1:0]  rbuf_q, rbuf_d;
  logic [CNT_W-1:0] discard_q, discard_d;

  logic             flush, resp_ok, ready_go, mem_allowin;
  logic [1:0]       disc_inc;
  logic             disc_dec;
  logic [SUM_W-1:0] disc_sum;
  logic [XLEN-1:0]  load_data, aligned, final_result;
  mem_to_wb_t       wb_bus;
  mem_rf_t          rf_bus;
  logic             unused_bits;

  assign bus_in      = exe_to_mem_bus_i;
  assign flush       = ertn_flush_i | wb_ex_i;
  // A response only belongs to the current entry once all orphaned ones are dropped
  assign resp_ok     = data_sram_data_ok_i & (discard_q == '0);
  assign ready_go    = (state_q != ST_WAIT) | resp_ok;
  assign mem_allowin = !mem_valid_q | (ready_go & wb_allowin_i);

  // Requests whose owner dies before the response arrives become orphans to drop
  assign disc_inc = 2'(flush & mem_valid_q & (state_q == ST_WAIT) & !resp_ok)
                  + 2'(data_req_fire_i & (flush | bus_in.ex));
  assign disc_dec = data_sram_data_ok_i & (discard_q != '0);
  assign disc_sum = SUM_W'(discard_q) + SUM_W'(disc_inc) - SUM_W'(disc_dec);
  assign discard_d = (disc_sum > SUM_W'(MAX_OUTST)) ? CNT_W'(MAX_OUTST) : CNT_W'(disc_sum);

  always_comb begin
    mem_valid_d = mem_valid_q;
    bus_d       = bus_q;
    state_d     = state_q;
    rbuf_d      = rbuf_q;
    if (state_q == ST_WAIT && resp_ok) begin
      rbuf_d  = data_sram_rdata_i;
      state_d = ST_HOLD;
    end
    if (mem_allowin) begin
      mem_valid_d = exe_to_mem_valid_i;
      state_d     = ST_IDLE;
      if (exe_to_mem_valid_i) begin
        bus_d = bus_in;
        if (data_req_fire_i && !bus_in.ex) begin
          state_d = ST_WAIT;
        end
      end
    end
    if (flush) begin
      mem_valid_d = 1'b0;
      state_d     = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mem_valid_q <= 1'b0;
      bus_q       <= '0;
      state_q     <= ST_IDLE;
      rbuf_q      <= '0;
      discard_q   <= '0;
    end else begin
      mem_valid_q <= mem_valid_d;
      bus_q       <= bus_d;
      state_q     <= state_d;
      rbuf_q      <= rbuf_d;
      discard_q   <= discard_d;
    end
  end

  assert property (@(posedge clk_i) disable iff (reset_i) disc_sum <= SUM_W'(MAX_OUTST));

  assign load_data = (state_q == ST_HOLD) ? rbuf_q : data_sram_rdata_i;

  mem_stage_load_align u_load_align (
    .rdata_i   (load_data),
    .off_i     (bus_q.exe_result[1:0]),
    .load_op_i (bus_q.load_op),
    .value_o   (aligned)
  );

  assign final_result = bus_q.rfrom_mem ? aligned : bus_q.exe_result;

  // Output buses read as zero whenever the stage holds no instruction
  always_comb begin
    wb_bus = '0;
    if (mem_valid_q) begin
      wb_bus.pc           = bus_q.pc;
      wb_bus.gr_we        = bus_q.gr_we & !bus_q.ex;
      wb_bus.dest         = bus_q.dest;
      wb_bus.final_result = final_result;
      wb_bus.csr_num      = bus_q.csr_num;
      wb_bus.csr_we       = bus_q.csr_we;
      wb_bus.csr_wvalue   = bus_q.csr_wvalue;
      wb_bus.csr_wmask    = bus_q.csr_wmask;
      wb_bus.ex           = bus_q.ex;
      wb_bus.ex_code      = bus_q.ex_code;
      wb_bus.ertn         = bus_q.ertn;
    end
  end

  always_comb begin
    rf_bus              = '0;
    rf_bus.dest         = bus_q.dest & {DEST_W{bus_q.gr_we & !bus_q.ex & mem_valid_q}};
    rf_bus.waiting_load = mem_valid_q & bus_q.rfrom_mem & !ready_go;
    rf_bus.valid        = mem_valid_q;
    if (mem_valid_q) begin
      rf_bus.final_result = final_result;
      rf_bus.csr_we       = bus_q.csr_we;
      rf_bus.csr_num      = bus_q.csr_num;
    end
  end

  assign mem_allowin_o     = mem_allowin;
  assign mem_to_wb_valid_o = mem_valid_q & ready_go;
  assign mem_to_wb_bus_o   = wb_bus;
  assign mem_rf_bus_o      = rf_bus;
  assign mem_ex_o          = mem_valid_q & bus_q.ex;
  assign mem_ertn_o        = mem_valid_q & bus_q.ertn;
  assign unused_bits       = ^{bus_q.st_data, bus_q.mem_en};

`ifdef MEM_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_q + 32'(mem_valid_q & (state_q == ST_WAIT));
    end
  end

  assign perf_load_stall_o = perf_q;
`endif

endmodule
